// File: rtl/proc_arb_pkg.sv
// Purpose: shared state encoding, issue-tag type and ID width helper for proc_input_arbiter.
// Latency: none, types and constants only.
// Backpressure: none, types and constants only.
package proc_arb_pkg;

   // Legacy-compatible state codes; the enum below is built on them
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      RUN   = ST_RUN,
      DRAIN = ST_DRAIN
   } arb_state_t;

   // Tag id is sized for the largest supported requester count (8)
   localparam int TAG_ID_W = 3;

   typedef struct packed {
      logic                valid;
      logic [TAG_ID_W-1:0] id;
   } tag_t;

   // Requester index width; a single requester still gets one bit
   function automatic int id_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Purpose: round-robin pick of one request, scanning upward from ptr+1 with wrap.
// Latency: purely combinational.
// Backpressure: grant is forced to zero while enable is low.
module rr_arbiter
   import proc_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = id_w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   input  logic               enable,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    idx,
   output logic               any
);

   // Scan distance of requester i from ptr: ptr+1 is 0, ptr itself is NUM_REQ-1
   function automatic int scan_dist(input int i, input logic [ID_W-1:0] p);
      return (i - int'(p) - 1 + 2 * NUM_REQ) % NUM_REQ;
   endfunction

   int best;

   // Winner is the valid requester with the smallest scan distance
   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      best  = NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (enable && req[i] && (scan_dist(i, ptr) < best)) begin
            best = scan_dist(i, ptr);
            idx  = ID_W'(i);
            any  = 1'b1;
         end
      end
      if (any) begin
         grant[idx] = 1'b1;
      end
   end

endmodule

// File: rtl/proc_input_arbiter.sv
// Purpose: round-robin share of one processor datapath, returning tagged results to requesters.
// Latency: issue at edge t -> rsp_valid visible after edge t+PROC_LAT+1.
// Backpressure: req_ready only in RUN; response path has no stall, one issue per cycle.
module proc_input_arbiter
   import proc_arb_pkg::*;
#(
   parameter int  NUM_REQ  = 4,
   parameter int  DATA_W   = 8,
   parameter int  PROC_LAT = 2,
   localparam int ID_W     = id_w(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cfg_enable,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [DATA_W-1:0]         proc_data_in,
   input  logic [DATA_W-1:0]         proc_data_out,
   output logic                      rsp_valid,
   output logic [ID_W-1:0]           rsp_id,
   output logic [DATA_W-1:0]         rsp_data,
   output logic                      busy
);

   arb_state_t        state;
   arb_state_t        state_nxt;
   logic [ID_W-1:0]   rr_ptr;
   logic [ID_W-1:0]   win_idx;
   logic              win_any;
   logic              run_en;
   logic [DATA_W-1:0] win_data;
   logic              tag_busy;

   // Stage 0 lines up with proc_data_in, stage PROC_LAT with proc_data_out
   tag_t tag_q [PROC_LAT+1];

   assign run_en = (state == RUN);

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rr (
      .req    (req_valid),
      .ptr    (rr_ptr),
      .enable (run_en),
      .grant  (req_ready),
      .idx    (win_idx),
      .any    (win_any)
   );

   // Select the winning requester's byte
   always_comb begin
      win_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win_idx == ID_W'(i)) begin
            win_data = req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   // Any issue still travelling through the tag pipe
   always_comb begin
      tag_busy = 1'b0;
      for (int i = 0; i <= PROC_LAT; i++) begin
         tag_busy = tag_busy | tag_q[i].valid;
      end
   end

   // Enable/drain control; re-enabling during a drain abandons it
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (cfg_enable) state_nxt = RUN;
         RUN:     if (!cfg_enable) state_nxt = DRAIN;
         DRAIN:   if (cfg_enable) state_nxt = RUN;
                  else if (!tag_busy) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State, issue data register and round-robin pointer
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         rr_ptr       <= ID_W'(NUM_REQ - 1);
         proc_data_in <= '0;
      end else begin
         state <= state_nxt;
         if (win_any) begin
            proc_data_in <= win_data;
            rr_ptr       <= win_idx;
         end
      end
   end

   // Tag pipe shifts every cycle; bubbles enter as invalid tags
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i <= PROC_LAT; i++) begin
            tag_q[i] <= '0;
         end
      end else begin
         tag_q[0] <= '{valid: win_any, id: TAG_ID_W'(win_idx)};
         for (int i = 1; i <= PROC_LAT; i++) begin
            tag_q[i] <= tag_q[i-1];
         end
      end
   end

   // Response register; id and data hold between pulses
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_data  <= '0;
      end else begin
         rsp_valid <= tag_q[PROC_LAT].valid;
         if (tag_q[PROC_LAT].valid) begin
            rsp_id   <= ID_W'(tag_q[PROC_LAT].id);
            rsp_data <= proc_data_out;
         end
      end
   end

   assign busy = (state != IDLE) | tag_busy | rsp_valid;

endmodule

// File: tb/tb_proc_input_arbiter.sv
// Purpose: self-checking bench for proc_input_arbiter against a queue-based reference model.
// Latency: model expects a response PROC_LAT+1 edges after each issue edge.
// Backpressure: processor model is a plain data_in+1 delay line with no stall.
module tb_proc_input_arbiter;
   localparam int NUM_REQ  = 4;
   localparam int DATA_W   = 8;
   localparam int PROC_LAT = 2;
   localparam int ID_W     = 2;

   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_DRAIN = 2;

   logic                      clk = 1'b0;
   logic                      rst = 1'b0;
   logic                      cfg_enable = 1'b0;
   logic [NUM_REQ-1:0]        req_valid = '0;
   logic [NUM_REQ*DATA_W-1:0] req_data = '0;
   logic [NUM_REQ-1:0]        req_ready;
   logic [DATA_W-1:0]         proc_data_in;
   logic [DATA_W-1:0]         proc_data_out;
   logic                      rsp_valid;
   logic [ID_W-1:0]           rsp_id;
   logic [DATA_W-1:0]         rsp_data;
   logic                      busy;

   proc_input_arbiter #(
      .NUM_REQ  (NUM_REQ),
      .DATA_W   (DATA_W),
      .PROC_LAT (PROC_LAT)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .cfg_enable    (cfg_enable),
      .req_valid     (req_valid),
      .req_data      (req_data),
      .req_ready     (req_ready),
      .proc_data_in  (proc_data_in),
      .proc_data_out (proc_data_out),
      .rsp_valid     (rsp_valid),
      .rsp_id        (rsp_id),
      .rsp_data      (rsp_data),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   // Processor: returns data_in+1, PROC_LAT edges after data_in is registered
   logic [DATA_W-1:0] ppipe [PROC_LAT];
   initial for (int i = 0; i < PROC_LAT; i++) ppipe[i] = '0;
   always @(posedge clk) begin
      ppipe[0] <= proc_data_in + 8'd1;
      for (int i = 1; i < PROC_LAT; i++) ppipe[i] <= ppipe[i-1];
   end
   assign proc_data_out = ppipe[PROC_LAT-1];

   // Reference model
   typedef struct {
      int         due;
      int         id;
      logic [7:0] data;
   } exp_t;

   exp_t       q[$];
   int         m_state;
   int         m_ptr;
   logic [7:0] m_pdi;
   int         m_rsp_id;
   logic [7:0] m_rsp_data;
   int         n;
   int         checks = 0;
   int         errors = 0;

   int         grant_log[$];
   int         grant_cyc[$];
   int         rsp_log_id[$];
   logic [7:0] rsp_log_data[$];
   int         rsp_cyc[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s n=%0d actual=%0h expected=%0h", name, n, act, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_state    = M_IDLE;
      m_ptr      = NUM_REQ - 1;
      m_pdi      = '0;
      m_rsp_id   = 0;
      m_rsp_data = '0;
   endtask

   task automatic clear_logs();
      grant_log.delete();
      grant_cyc.delete();
      rsp_log_id.delete();
      rsp_log_data.delete();
      rsp_cyc.delete();
   endtask

   // Called at a negedge with inputs applied: check outputs, advance model over next edge
   task automatic tick();
      logic [NUM_REQ-1:0] exp_ready;
      logic               exp_rv;
      logic               exp_busy;
      logic [7:0]         d;
      int                 win;
      int                 c;
      #1;
      exp_ready = '0;
      win = -1;
      if (m_state == M_RUN) begin
         for (int k = 1; k <= NUM_REQ; k++) begin
            c = (m_ptr + k) % NUM_REQ;
            if (win < 0 && req_valid[c]) win = c;
         end
         if (win >= 0) exp_ready[win] = 1'b1;
      end
      exp_rv   = (q.size() > 0) && (q[0].due == n);
      exp_busy = (m_state != M_IDLE) || (q.size() > 0);
      if (exp_rv) begin
         m_rsp_id   = q[0].id;
         m_rsp_data = q[0].data;
         void'(q.pop_front());
      end
      chk("req_ready", req_ready, exp_ready);
      chk("rsp_valid", rsp_valid, exp_rv);
      chk("rsp_id", rsp_id, m_rsp_id);
      chk("rsp_data", rsp_data, m_rsp_data);
      chk("busy", busy, exp_busy);
      chk("proc_data_in", proc_data_in, m_pdi);

      if (|(req_ready & req_valid)) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
               grant_log.push_back(i);
               grant_cyc.push_back(n);
            end
         end
      end
      if (rsp_valid === 1'b1) begin
         rsp_log_id.push_back(int'(rsp_id));
         rsp_log_data.push_back(rsp_data);
         rsp_cyc.push_back(n);
      end

      if (win >= 0) begin
         m_pdi = req_data[win*DATA_W +: DATA_W];
         d     = m_pdi + 8'd1;
         q.push_back('{due: n + PROC_LAT + 2, id: win, data: d});
         m_ptr = win;
      end
      case (m_state)
         M_IDLE:  if (cfg_enable) m_state = M_RUN;
         M_RUN:   if (!cfg_enable) m_state = M_DRAIN;
         default: if (cfg_enable) m_state = M_RUN;
                  else if (q.size() == 0) m_state = M_IDLE;
      endcase
      @(negedge clk);
      n++;
   endtask

   // Asynchronous reset held across one edge, reset values pinned literally
   task automatic do_reset();
      rst = 1'b0;
      #1;
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_proc_data_in", proc_data_in, 0);
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      n++;
      clear_logs();
   endtask

   task automatic drain();
      cfg_enable = 1'b0;
      req_valid  = '0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (m_state == M_IDLE && q.size() == 0) break;
      end
      #1;
      chk("drain_busy", busy, 0);
   endtask

   initial begin
      logic [7:0] s2_data [4];
      int         s3_g [4];
      int         s6_id [5];
      s2_data = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
      s3_g    = '{1, 3, 1, 3};
      s6_id   = '{0, 1, 2, 3, 0};
      n = 0;
      model_reset();
      @(negedge clk);
      do_reset();

      // S1: single issue from requester 0
      cfg_enable = 1'b1;
      req_valid  = 4'b0001;
      req_data   = '0;
      req_data[7:0] = 8'h10;
      tick();
      tick();
      req_valid = '0;
      repeat (5) tick();
      drain();
      chk("s1_rsp_count", rsp_log_id.size(), 1);
      chk("s1_grant", grant_log[0], 0);
      chk("s1_rsp_id", rsp_log_id[0], 0);
      chk("s1_rsp_data", rsp_log_data[0], 8'h11);
      chk("s1_latency", rsp_cyc[0] - grant_cyc[0] - 1, 3);

      // S2: all valid, round-robin from requester 0
      do_reset();
      req_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
      req_valid  = 4'b1111;
      cfg_enable = 1'b1;
      repeat (6) tick();
      drain();
      for (int i = 0; i < 5; i++) chk("s2_grant", grant_log[i], i % 4);
      for (int i = 0; i < 4; i++) begin
         chk("s2_rsp_id", rsp_log_id[i], i);
         chk("s2_rsp_data", rsp_log_data[i], s2_data[i]);
      end
      chk("s2_consecutive", rsp_cyc[3] - rsp_cyc[0], 3);

      // S3: only 1 and 3 valid, pointer at 3
      do_reset();
      req_valid  = 4'b1010;
      cfg_enable = 1'b1;
      repeat (5) tick();
      drain();
      chk("s3_grant_count", grant_log.size(), 4);
      for (int i = 0; i < 4; i++) chk("s3_grant", grant_log[i], s3_g[i]);

      // S4: four back-to-back, enable drops with the fourth transfer
      do_reset();
      req_valid  = 4'b1111;
      cfg_enable = 1'b1;
      repeat (4) tick();
      cfg_enable = 1'b0;
      tick();
      #1;
      chk("s4_ready_off", req_ready, 0);
      drain();
      chk("s4_grant_count", grant_log.size(), 4);
      chk("s4_rsp_count", rsp_log_id.size(), 4);

      // S5: reset with two issues in flight
      do_reset();
      req_data[7:0] = 8'h55;
      req_valid  = 4'b0001;
      cfg_enable = 1'b1;
      repeat (3) tick();
      req_valid = '0;
      tick();
      do_reset();
      cfg_enable = 1'b0;
      repeat (6) tick();
      chk("s5_no_stale", rsp_log_id.size(), 0);
      req_data[15:8] = 8'h77;
      req_valid  = 4'b0010;
      cfg_enable = 1'b1;
      tick();
      tick();
      drain();
      chk("s5_rsp_count", rsp_log_id.size(), 1);
      chk("s5_rsp_id", rsp_log_id[0], 1);
      chk("s5_rsp_data", rsp_log_data[0], 8'h78);

      // S6: drain abandoned by re-enable
      do_reset();
      req_data   = $urandom;
      req_valid  = 4'b1111;
      cfg_enable = 1'b1;
      tick();
      tick();
      cfg_enable = 1'b0;
      tick();
      tick();
      cfg_enable = 1'b1;
      tick();
      #1;
      chk("s6_resume", |req_ready, 1);
      repeat (3) tick();
      drain();
      chk("s6_rsp_count", rsp_log_id.size(), 5);
      for (int i = 0; i < 5; i++) chk("s6_order", rsp_log_id[i], s6_id[i]);

      // Random traffic with occasional reset
      for (int i = 0; i < 600; i++) begin
         cfg_enable = ($urandom_range(0, 7) != 0);
         req_valid  = 4'($urandom);
         req_data   = $urandom;
         if ($urandom_range(0, 199) == 0) do_reset();
         else tick();
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
